frame_min_max_tracker: RTL and testbench

- Streaming consumer of magnitude-compare results: accepts one unsigned WIDTH-bit sample per handshake, tracks running max, running min, their sample indices and sample count over a frame terminated by in_last.
- Presents one result record per frame on a valid/ready output.
- Sits directly downstream of the combinational magnitude comparator, which it instantiates twice: sample vs. max, sample vs. min.

---
 rtl/frame_track_pkg.sv | 22 ++
 rtl/mag_compare.sv | 29 ++
 rtl/frame_min_max_tracker.sv | 126 ++++++++++++
 tb/tb_frame_min_max_tracker.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/frame_track_pkg.sv
// Shared types and default widths for the frame min/max tracker.
// frame_result_t is the default-width record layout seen by downstream consumers.
package frame_track_pkg;

  localparam int unsigned DefWidth = 20;
  localparam int unsigned DefIdxW  = 8;

  typedef enum logic [1:0] {
    StIdle,
    StAccum,
    StHold
  } state_e;

  typedef struct packed {
    logic [DefWidth-1:0] max;
    logic [DefWidth-1:0] min;
    logic [DefIdxW-1:0]  max_idx;
    logic [DefIdxW-1:0]  min_idx;
    logic [DefIdxW:0]    count;
  } frame_result_t;

endpackage

// File: rtl/mag_compare.sv
// Combinational unsigned magnitude comparator.
// The most significant differing bit decides the result.
module mag_compare #(
  parameter int unsigned WIDTH = 20
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             gt,
  output logic             lt,
  output logic             eq
);

  logic found;

  always_comb begin
    gt    = 1'b0;
    lt    = 1'b0;
    found = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (!found && (a[i] != b[i])) begin
        gt    = a[i];
        lt    = b[i];
        found = 1'b1;
      end
    end
    eq = !found;
  end

endmodule

// File: rtl/frame_min_max_tracker.sv
// Tracks max/min value, their first-occurrence indices and sample count per frame,
// then holds one result record on a valid/ready output until it is consumed.
module frame_min_max_tracker
  import frame_track_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth,
  parameter int unsigned IDX_W = DefIdxW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_max,
  output logic [WIDTH-1:0] out_min,
  output logic [IDX_W-1:0] out_max_idx,
  output logic [IDX_W-1:0] out_min_idx,
  output logic [IDX_W:0]   out_count,
  output logic             out_valid,
  input  logic             out_ready
);

  // Same layout as frame_result_t, but sized by this instance's parameters.
  typedef struct packed {
    logic [WIDTH-1:0] max;
    logic [WIDTH-1:0] min;
    logic [IDX_W-1:0] max_idx;
    logic [IDX_W-1:0] min_idx;
    logic [IDX_W:0]   count;
  } result_t;

  localparam logic [IDX_W:0]   CountMax = {1'b1, {IDX_W{1'b0}}};
  localparam logic [IDX_W-1:0] IdxMax   = {IDX_W{1'b1}};

  state_e           state_q, state_d;
  result_t          res_q, res_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  logic max_gt, max_lt, max_eq;
  logic min_gt, min_lt, min_eq;
  logic unused_cmp;

  mag_compare #(.WIDTH(WIDTH)) u_cmp_max (
    .a  (in_data),
    .b  (res_q.max),
    .gt (max_gt),
    .lt (max_lt),
    .eq (max_eq)
  );

  mag_compare #(.WIDTH(WIDTH)) u_cmp_min (
    .a  (in_data),
    .b  (res_q.min),
    .gt (min_gt),
    .lt (min_lt),
    .eq (min_eq)
  );

  // Only strict gt/lt drive updates; equal samples keep the first occurrence.
  assign unused_cmp = max_lt ^ max_eq ^ min_gt ^ min_eq;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      res_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    res_d     = res_q;
    idx_d     = idx_q;
    in_ready  = (state_q != StHold);
    out_valid = (state_q == StHold);

    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          res_d.max     = in_data;
          res_d.min     = in_data;
          res_d.max_idx = '0;
          res_d.min_idx = '0;
          res_d.count   = {{IDX_W{1'b0}}, 1'b1};
          idx_d         = {{(IDX_W-1){1'b0}}, 1'b1};
          state_d       = in_last ? StHold : StAccum;
        end
      end
      StAccum: begin
        if (in_valid) begin
          if (max_gt) begin
            res_d.max     = in_data;
            res_d.max_idx = idx_q;
          end
          if (min_lt) begin
            res_d.min     = in_data;
            res_d.min_idx = idx_q;
          end
          res_d.count = (res_q.count == CountMax) ? res_q.count : res_q.count + 1'b1;
          idx_d       = (idx_q == IdxMax) ? idx_q : idx_q + 1'b1;
          if (in_last) begin
            state_d = StHold;
          end
        end
      end
      StHold: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign out_max     = res_q.max;
  assign out_min     = res_q.min;
  assign out_max_idx = res_q.max_idx;
  assign out_min_idx = res_q.min_idx;
  assign out_count   = res_q.count;

endmodule

// File: tb/tb_frame_min_max_tracker.sv
// Directed bench: expected records are queued when a frame's last sample is driven
// and popped when the DUT presents its record.
module tb_frame_min_max_tracker;
  import frame_track_pkg::*;

  localparam int unsigned W  = DefWidth;
  localparam int unsigned IW = DefIdxW;

  logic          clk;
  logic          rst_n;
  logic [W-1:0]  in_data;
  logic          in_valid, in_last, in_ready;
  logic [W-1:0]  out_max, out_min;
  logic [IW-1:0] out_max_idx, out_min_idx;
  logic [IW:0]   out_count;
  logic          out_valid, out_ready;

  logic          in_valid2, in_last2, in_ready2;
  logic [W-1:0]  out_max2, out_min2;
  logic [1:0]    out_max_idx2, out_min_idx2;
  logic [2:0]    out_count2;
  logic          out_valid2, out_ready2;

  frame_min_max_tracker #(.WIDTH(W), .IDX_W(IW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_last     (in_last),
    .in_ready    (in_ready),
    .out_max     (out_max),
    .out_min     (out_min),
    .out_max_idx (out_max_idx),
    .out_min_idx (out_min_idx),
    .out_count   (out_count),
    .out_valid   (out_valid),
    .out_ready   (out_ready)
  );

  frame_min_max_tracker #(.WIDTH(W), .IDX_W(2)) dut_sat (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_data     (in_data),
    .in_valid    (in_valid2),
    .in_last     (in_last2),
    .in_ready    (in_ready2),
    .out_max     (out_max2),
    .out_min     (out_min2),
    .out_max_idx (out_max_idx2),
    .out_min_idx (out_min_idx2),
    .out_count   (out_count2),
    .out_valid   (out_valid2),
    .out_ready   (out_ready2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  frame_result_t exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic frame_result_t mk(input logic [W-1:0] mx, input logic [W-1:0] mn,
                                       input logic [IW-1:0] mxi, input logic [IW-1:0] mni,
                                       input logic [IW:0] cnt);
    frame_result_t r;
    r.max     = mx;
    r.min     = mn;
    r.max_idx = mxi;
    r.min_idx = mni;
    r.count   = cnt;
    return r;
  endfunction

  // Drive one sample and hold it until accepted (bounded).
  task automatic send(input logic [W-1:0] d, input logic last);
    int n;
    n = 0;
    @(negedge clk);
    in_data  = d;
    in_valid = 1'b1;
    in_last  = last;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("send_ready_timeout", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Called on the negedge right after the last-sample transfer.
  task automatic pop_and_check(input string tag);
    frame_result_t e;
    e = exp_q.pop_front();
    chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd0);
    chk({tag, "_max"}, out_max, e.max);
    chk({tag, "_min"}, out_min, e.min);
    chk({tag, "_max_idx"}, out_max_idx, e.max_idx);
    chk({tag, "_min_idx"}, out_min_idx, e.min_idx);
    chk({tag, "_count"}, out_count, e.count);
  endtask

  task automatic expect_record(input string tag);
    @(negedge clk);
    pop_and_check(tag);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    chk({tag, "_drop_valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_ready_back"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n      = 1'b0;
    in_data    = '0;
    in_valid   = 1'b0;
    in_last    = 1'b0;
    out_ready  = 1'b0;
    in_valid2  = 1'b0;
    in_last2   = 1'b0;
    out_ready2 = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    @(negedge clk);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_max", out_max, 32'd0);
    chk("rst_min", out_min, 32'd0);
    chk("rst_count", out_count, 32'd0);
    chk("rst_sat_valid", {31'd0, out_valid2}, 32'd0);

    // Single-sample frame
    exp_q.push_back(mk(20'h00055, 20'h00055, 0, 0, 1));
    send(20'h00055, 1'b1);
    expect_record("single");

    // Ties at indices 3/4 must not move indices
    exp_q.push_back(mk(9, 1, 2, 5, 6));
    send(7, 0); send(3, 0); send(9, 0); send(3, 0); send(9, 0); send(1, 1);
    expect_record("ties");

    // Full-width unsigned compare
    exp_q.push_back(mk(20'hFFFFF, 20'h00000, 0, 1, 3));
    send(20'hFFFFF, 0); send(20'h00000, 0); send(20'h80000, 1);
    expect_record("fullw");

    // Back-pressure with a pending sample
    exp_q.push_back(mk(20, 10, 1, 0, 2));
    send(10, 0); send(20, 1);
    @(negedge clk);
    pop_and_check("stall");
    in_data  = 20'h33;
    in_valid = 1'b1;
    in_last  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
      chk("stall_valid", {31'd0, out_valid}, 32'd1);
      chk("stall_max", out_max, 32'd20);
      chk("stall_min", out_min, 32'd10);
      chk("stall_count", out_count, 32'd2);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    chk("stall_drop_valid", {31'd0, out_valid}, 32'd0);
    chk("stall_ready_back", {31'd0, in_ready}, 32'd1);
    exp_q.push_back(mk(20'h33, 20'h33, 0, 0, 1));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    expect_record("pending");

    // Reset mid-frame discards the partial frame
    send(50, 0); send(60, 0); send(5, 0);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("mrst_valid", {31'd0, out_valid}, 32'd0);
    chk("mrst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("mrst_max", out_max, 32'd0);
    chk("mrst_min", out_min, 32'd0);
    chk("mrst_max_idx", out_max_idx, 32'd0);
    chk("mrst_min_idx", out_min_idx, 32'd0);
    chk("mrst_count", out_count, 32'd0);
    exp_q.push_back(mk(4, 2, 0, 1, 2));
    send(4, 0); send(2, 1);
    expect_record("after_rst");

    // Saturation on the IDX_W=2 instance
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      chk("sat_in_ready", {31'd0, in_ready2}, 32'd1);
      in_data   = W'(i);
      in_valid2 = 1'b1;
      in_last2  = (i == 6);
      @(posedge clk);
      #1;
    end
    in_valid2 = 1'b0;
    in_last2  = 1'b0;
    @(negedge clk);
    chk("sat_valid", {31'd0, out_valid2}, 32'd1);
    chk("sat_count", out_count2, 32'd4);
    chk("sat_max", out_max2, 32'd6);
    chk("sat_max_idx", out_max_idx2, 32'd3);
    chk("sat_min", out_min2, 32'd1);
    chk("sat_min_idx", out_min_idx2, 32'd0);
    out_ready2 = 1'b1;
    @(posedge clk);
    #1 out_ready2 = 1'b0;
    @(negedge clk);
    chk("sat_drop_valid", {31'd0, out_valid2}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
